// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeds a start/data/stop serialiser
// running at DIV system clocks per bit. All outputs are registered.
module uart_tx_fifo #(
    parameter int sysclk_frequency = 1330,  // units of 10 kHz
    parameter int baud             = 115200,
    parameter int fifo_log2        = 4
) (
    input  logic       clk,
    input  logic       reset_in,
    input  logic [7:0] d,
    input  logic       wr,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    output logic       txd
);

    // DIV must come out at 2 or more for the bit timing to be meaningful.
    localparam int DIV    = (sysclk_frequency * 10000) / baud;
    localparam int DEPTH  = 1 << fifo_log2;
    localparam int BAUD_W = $clog2(DIV);

    typedef logic [fifo_log2-1:0] ptr_t;
    typedef logic [fifo_log2:0]   count_t;
    typedef logic [BAUD_W-1:0]    baud_t;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    localparam count_t COUNT_FULL = count_t'(DEPTH);
    localparam baud_t  BAUD_LAST  = baud_t'(DIV - 1);

    state_t     state_q, state_d;
    baud_t      baud_cnt_q, baud_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    ptr_t       wr_ptr_q, wr_ptr_d;
    count_t     count_q, count_d;
    logic       overflow_q, overflow_d;
    logic       txd_q, txd_d;
    logic       full_q, full_d;
    logic       empty_q, empty_d;
    logic       busy_q, busy_d;
    logic       pop, push, bit_end;
    logic [7:0] mem_q [DEPTH];

    assign bit_end = (baud_cnt_q == BAUD_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            txd_q      <= 1'b1;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every flop samples the pre-edge values.
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            txd_q      <= txd_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            busy_q     <= busy_d;
        end
    end

    // NOTE: storage is not reset; a reset empties the FIFO by clearing pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= d;
    end

    // Next-state logic: serialiser FSM plus FIFO bookkeeping.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    shift_d    = mem_q[rd_ptr_q];
                    baud_cnt_d = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + baud_t'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    bit_idx_d  = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + baud_t'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + baud_t'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        push       = wr && ((count_q != COUNT_FULL) || pop);
        overflow_d = overflow_q | (wr & ~push);
        rd_ptr_d   = pop  ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + count_t'(1);
            2'b01:   count_d = count_q - count_t'(1);
            default: count_d = count_q;
        endcase
    end

    // Output logic, computed from next-state values so the registers show this cycle's result.
    always_comb begin
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        full_d  = (count_d == COUNT_FULL);
        empty_d = (count_d == '0);
        busy_d  = (state_d != S_IDLE) || (count_d != '0);
    end

    assign txd      = txd_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule
